// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
// Event indices double as priority ranks: the lowest legal index wins.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;
    localparam int unsigned LAP_W_DEFAULT           = 4;

    localparam int unsigned EV_STOP  = 0;
    localparam int unsigned EV_START = 1;
    localparam int unsigned EV_LAP   = 2;
    localparam int unsigned EV_CLEAR = 3;
    localparam int unsigned EV_NUM   = 4;

    // Events each state responds to; anything else is dropped.
    function automatic logic [EV_NUM-1:0] legal_events(input sw_state_t s);
        logic [EV_NUM-1:0] m;
        case (s)
            IDLE:    m = 4'b1010;
            RUN:     m = 4'b0101;
            LAP:     m = 4'b0111;
            PAUSE:   m = 4'b1010;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Index of the highest-priority asserted event, EV_NUM when none.
    function automatic logic [2:0] pick_event(input logic [EV_NUM-1:0] ev);
        logic [2:0] sel;
        sel = 3'(EV_NUM);
        for (int i = int'(EV_NUM) - 1; i >= 0; i--) begin
            if (ev[i]) begin
                sel = 3'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stable-level debounce
// and a single-cycle registered pulse on each accepted press.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             press_r;

    // Synchronise, count consecutive mismatches, and emit rising-level pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r    <= 2'b00;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], btn};
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
            if (sync_r[1] == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                level_r <= ~level_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap sequencer: conditions four buttons, gates the ms
// tick into the counter chain, issues clear and lap-latch strobes.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LAP_W           = LAP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_lap,
    input  logic             btn_clear,
    input  logic             tick_in,
    output logic             count_tick,
    output logic             count_en,
    output logic             count_clr,
    output logic             disp_freeze,
    output logic             lap_strobe,
    output logic [LAP_W-1:0] lap_count,
    output logic [1:0]       state
);

    localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};

    logic [EV_NUM-1:0] ev_s;
    logic [2:0]        sel_s;
    sw_state_t         state_r;
    sw_state_t         next_state_s;
    logic              do_clr_s;
    logic              do_lap_s;
    logic [LAP_W-1:0]  lap_count_r;
    logic [LAP_W-1:0]  lap_nxt_s;
    logic              count_en_r;
    logic              count_en_nxt_s;
    logic              freeze_r;
    logic              freeze_nxt_s;
    logic              count_clr_r;
    logic              lap_strobe_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clk), .reset_n(reset_n), .btn(btn_stop), .press(ev_s[EV_STOP])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .reset_n(reset_n), .btn(btn_start), .press(ev_s[EV_START])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk(clk), .reset_n(reset_n), .btn(btn_lap), .press(ev_s[EV_LAP])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .reset_n(reset_n), .btn(btn_clear), .press(ev_s[EV_CLEAR])
    );

    // Simultaneous presses collapse to the single winning legal event.
    assign sel_s = pick_event(ev_s & legal_events(state_r));

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            lap_count_r  <= '0;
            count_en_r   <= 1'b0;
            freeze_r     <= 1'b0;
            count_clr_r  <= 1'b0;
            lap_strobe_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            lap_count_r  <= lap_nxt_s;
            count_en_r   <= count_en_nxt_s;
            freeze_r     <= freeze_nxt_s;
            count_clr_r  <= do_clr_s;
            lap_strobe_r <= do_lap_s;
        end
    end

    // Next-state decode from the selected event.
    always_comb begin
        next_state_s = state_r;
        do_clr_s     = 1'b0;
        do_lap_s     = 1'b0;
        case (sel_s)
            3'(EV_STOP):  next_state_s = PAUSE;
            3'(EV_START): next_state_s = RUN;
            3'(EV_LAP): begin
                next_state_s = LAP;
                do_lap_s     = 1'b1;
            end
            3'(EV_CLEAR): begin
                next_state_s = IDLE;
                do_clr_s     = 1'b1;
            end
            default: next_state_s = state_r;
        endcase
    end

    // Output values for the coming cycle; lap count saturates.
    always_comb begin
        lap_nxt_s = lap_count_r;
        if (do_clr_s) begin
            lap_nxt_s = '0;
        end else if (do_lap_s && (lap_count_r != LAP_MAX)) begin
            lap_nxt_s = lap_count_r + LAP_W'(1);
        end else begin
            lap_nxt_s = lap_count_r;
        end
        count_en_nxt_s = (next_state_s == RUN) || (next_state_s == LAP);
        freeze_nxt_s   = (next_state_s == LAP);
    end

    assign count_tick  = tick_in & count_en_r;
    assign count_en    = count_en_r;
    assign count_clr   = count_clr_r;
    assign disp_freeze = freeze_r;
    assign lap_strobe  = lap_strobe_r;
    assign lap_count   = lap_count_r;
    assign state       = state_r;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch counting datapath. It takes four raw push-buttons (start, stop, lap, clear), synchronises and debounces each one, and runs a run/pause/lap state machine. The state machine gates the 1 ms tick into the counter chain, issues a single-cycle clear, and freezes the display for lap times. It sits between the board buttons and the ms/sec/min counters plus the BCD/7-seg display path.

Parameters:
- DEBOUNCE_CYCLES, 500_000: consecutive stable clk cycles (10 ms at 50 MHz) needed to accept a button level change.
- LAP_W, 4: width of the lap counter.

Ports:
- clk, input, 1: 50 MHz system clock.
- reset_n, input, 1: asynchronous active-low reset.
- btn_start, input, 1: raw start button, active-high, asynchronous to clk.
- btn_stop, input, 1: raw stop button, active-high, asynchronous to clk.
- btn_lap, input, 1: raw lap button, active-high, asynchronous to clk.
- btn_clear, input, 1: raw clear button, active-high, asynchronous to clk.
- tick_in, input, 1: 1-cycle tick from the millisecond divider.
- count_tick, output, 1: tick_in AND count_en; combinational, same cycle as tick_in.
- count_en, output, 1: counters may advance.
- count_clr, output, 1: 1-cycle pulse that zeroes the ms/sec/min counters.
- disp_freeze, output, 1: display holds the latched lap value.
- lap_strobe, output, 1: 1-cycle pulse; display latches the current count.
- lap_count, output, LAP_W: number of laps taken since the last clear.
- state, output, 2: current FSM state, for debug and LEDs.

Behaviour:
- Reset (reset_n=0, async), all cleared immediately:
  - state=IDLE.
  - All outputs 0, lap_count=0.
  - Sync flops, debounced levels and debounce counters all 0.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter:
    - While the synchronised value differs from the debounced level, the counter increments.
    - When it matches, the counter resets to 0.
    - At DEBOUNCE_CYCLES consecutive mismatches the debounced level toggles and the counter resets.
  - Press pulse = debounced level 0->1, registered, exactly 1 cycle.
  - Release produces no pulse.
  - A held button yields one pulse only.
- Latency: raw 0->1 edge to press pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. The FSM reacts to the pulse on the next clk edge.
- FSM states: IDLE=0, RUN=1, LAP=2, PAUSE=3.
  - IDLE: count_en=0, freeze=0.
    - start -> RUN.
    - clear -> count_clr pulse, lap_count=0, stay IDLE.
  - RUN: count_en=1, freeze=0.
    - stop -> PAUSE.
    - lap -> LAP, with lap_strobe pulse and lap_count+1.
    - start and clear are ignored.
  - LAP: count_en=1, freeze=1 (counting continues while the display is held).
    - lap -> LAP again, with a fresh lap_strobe and lap_count+1.
    - start -> RUN (display released).
    - stop -> PAUSE (freeze drops).
    - clear is ignored.
  - PAUSE: count_en=0, freeze=0.
    - start -> RUN.
    - clear -> IDLE, with count_clr pulse and lap_count=0.
    - lap is ignored.
- Simultaneous pulses in one cycle: priority is stop > start > lap > clear. Only the highest-priority event that is legal in the current state acts; the rest are dropped, not queued.
- lap_count saturates at 2^LAP_W-1; a further lap still pulses lap_strobe.
- Output timing: count_clr and lap_strobe are registered and asserted in the cycle the FSM enters or stays in the target state.
- count_en changes on the state-transition edge. A tick_in coincident with the transition edge uses the pre-edge count_en.
- reset_n asserted mid-debounce or mid-LAP: everything returns to reset values immediately. No pulse is generated on reset release, even if a button is held (debounced level starts at 0, so the button must be held a full DEBOUNCE_CYCLES before it registers).

Decomposition:
- stopwatch_pkg holds:
  - sw_state_t enum (IDLE/RUN/LAP/PAUSE, 2 bits).
  - DEBOUNCE_CYCLES_DEFAULT=500_000 and LAP_W_DEFAULT=4.
  - Event priority order constants.
- One sub-module, btn_debounce (synchroniser + debounce counter + press-pulse), instantiated four times. Counter width = $clog2(DEBOUNCE_CYCLES+1).
- The FSM and lap counter live in stopwatch_ctrl.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset: hold reset_n=0 with btn_start=1 throughout, then release -> state=0 and all outputs 0. Exactly one start pulse 7 cycles after release, then state=1 (RUN).
2. Bounce rejection: btn_start toggles every 2 cycles for 20 cycles, then holds 1 -> no pulse during toggling. One pulse 7 cycles after the final stable edge; state goes IDLE->RUN.
3. Run/pause gating: in RUN apply tick_in every 10 cycles -> count_tick mirrors tick_in. Press stop -> state=3 and count_tick=0 for all later ticks. Press start -> ticks pass again.
4. Lap: from RUN press lap 3 times -> three lap_strobe pulses, lap_count=3, disp_freeze=1 and count_en=1 throughout. Press start -> state=1, freeze=0.
5. Clear rules:
   - clear in RUN -> ignored, no count_clr.
   - stop then clear -> count_clr high exactly 1 cycle, lap_count=0, state=0.
   - 16 laps with LAP_W=4 -> lap_count saturates at 15.
6. Simultaneous events: force stop and start pulses in the same cycle while in RUN -> PAUSE. Force start and lap together in PAUSE -> RUN, no lap_strobe.
